// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry constants and refill state encoding
package cache_pkg;

    localparam int LINE_BYTES = 64;
    localparam int BEAT_BYTES = 8;
    localparam int BEATS      = 8;
    localparam int INDEX_W    = 6;
    localparam int OFFSET_W   = 6;
    localparam int BEAT_W     = BEAT_BYTES * 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_BEAT,
        ST_WRITE,
        ST_DONE
    } refill_state_t;

endpackage

// File: rtl/cache_refill_ser.sv
// rtl/cache_refill_ser.sv - holds one memory beat and walks it out a byte per cycle
module cache_refill_ser
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [BEAT_W-1:0] data,
    output logic              busy,
    output logic [7:0]        byte_out,
    output logic [2:0]        byte_idx,
    output logic              last_byte
);

    logic [BEAT_W-1:0] beat_buf;

    // A load starts an 8-cycle burst on its own; busy drops after byte 7.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_buf <= '0;
            byte_idx <= '0;
            busy     <= 1'b0;
        end else if (load) begin
            beat_buf <= data;
            byte_idx <= '0;
            busy     <= 1'b1;
        end else if (busy) begin
            if (byte_idx == 3'd7) begin
                busy <= 1'b0;
            end else begin
                byte_idx <= byte_idx + 3'd1;
            end
        end
    end

    assign byte_out  = beat_buf[{byte_idx, 3'b000} +: 8];
    assign last_byte = busy && (byte_idx == 3'd7);

endmodule

// File: rtl/cache_refill.sv
// rtl/cache_refill.sv - line-fill engine from memory beats to cache RAM byte writes
module cache_refill
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                refill_valid,
    output logic                refill_ready,
    input  logic [ADDR_W-1:0]   refill_addr,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_rsp_valid,
    output logic                mem_rsp_ready,
    input  logic [BEAT_W-1:0]   mem_rsp_data,
    input  logic                mem_rsp_last,
    output logic                ram_wen,
    output logic [INDEX_W-1:0]  ram_index,
    output logic [OFFSET_W-1:0] ram_offset,
    output logic [7:0]          ram_data,
    output logic                done,
    output logic                err
);

    localparam logic [2:0]        LAST_BEAT = 3'(BEATS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_BYTES - 1);

    refill_state_t       state;
    logic [2:0]          beat;
    logic [ADDR_W-1:0]   line_addr;
    logic [INDEX_W-1:0]  index_q;
    logic                beat_load;
    logic                ser_busy;
    logic                ser_last;
    logic [2:0]          byte_idx;
    logic [7:0]          byte_out;

    assign beat_load = mem_rsp_ready && mem_rsp_valid;

    cache_refill_ser u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (beat_load),
        .data      (mem_rsp_data),
        .busy      (ser_busy),
        .byte_out  (byte_out),
        .byte_idx  (byte_idx),
        .last_byte (ser_last)
    );

    // Handshake outputs are registered and set on the transition into their state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            refill_ready  <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_rsp_ready <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            beat          <= '0;
            line_addr     <= '0;
            index_q       <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (refill_valid) begin
                        line_addr     <= refill_addr & LINE_MASK;
                        index_q       <= refill_addr[11:6];
                        beat          <= '0;
                        err           <= 1'b0;
                        refill_ready  <= 1'b0;
                        mem_req_valid <= 1'b1;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        mem_rsp_ready <= 1'b1;
                        state         <= ST_BEAT;
                    end
                end
                ST_BEAT: begin
                    if (mem_rsp_valid) begin
                        mem_rsp_ready <= 1'b0;
                        // The beat counter decides the fill length; last only flags disagreement.
                        if (mem_rsp_last != (beat == LAST_BEAT)) begin
                            err <= 1'b1;
                        end
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (ser_last) begin
                        if (beat == LAST_BEAT) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            beat          <= beat + 3'd1;
                            mem_rsp_ready <= 1'b1;
                            state         <= ST_BEAT;
                        end
                    end
                end
                ST_DONE: begin
                    done         <= 1'b0;
                    refill_ready <= 1'b1;
                    state        <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req_addr = line_addr;
    assign ram_wen      = ser_busy;
    assign ram_index    = index_q;
    assign ram_offset   = {beat, byte_idx};
    assign ram_data     = byte_out;

endmodule

// File: tb/tb_cache_refill.sv
// tb/tb_cache_refill.sv - scoreboard bench for cache_refill with a behavioural memory
module tb_cache_refill;

    logic        clk = 1'b0;
    logic        rst;
    logic        refill_valid;
    logic        refill_ready;
    logic [31:0] refill_addr;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [63:0] mem_rsp_data;
    logic        mem_rsp_last;
    logic        ram_wen;
    logic [5:0]  ram_index;
    logic [5:0]  ram_offset;
    logic [7:0]  ram_data;
    logic        done;
    logic        err;

    cache_refill #(.ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .refill_valid  (refill_valid),
        .refill_ready  (refill_ready),
        .refill_addr   (refill_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_data  (mem_rsp_data),
        .mem_rsp_last  (mem_rsp_last),
        .ram_wen       (ram_wen),
        .ram_index     (ram_index),
        .ram_offset    (ram_offset),
        .ram_data      (ram_data),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected write: {err, index, offset, data}
    logic [20:0] exp_q[$];
    logic [63:0] mem_q[$];
    int          done_cyc_q[$];
    logic        done_err_q[$];
    int          rdy_q[$];

    int          req_wait  = 0;
    int          beat_wait = 0;
    bit          hold      = 0;
    int          bad_beat  = -1;
    logic [63:0] fill_data [8];
    logic [31:0] prev_line  = '0;
    logic [5:0]  prev_index = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        $display("FAIL %s: timed out waiting for DUT (cycle %0d)", name, cyc);
    endtask

    // Memory: req accepted after req_wait cycles, each beat offered after beat_wait ready cycles.
    initial begin : mem_model
        logic rst_s, p_req_v, p_rsp_r;
        int   beat_no, rcnt, wcnt;
        rst_s = 1'b1; p_req_v = 1'b0; p_rsp_r = 1'b0;
        beat_no = 0; rcnt = 0; wcnt = 0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        mem_rsp_data = '0; mem_rsp_last = 1'b0;
        forever begin
            @(negedge clk);
            rst_s   = rst;
            p_req_v = mem_req_valid;
            p_rsp_r = mem_rsp_ready;
            @(posedge clk); #1;
            if (rst_s) begin
                mem_q.delete();
                beat_no = 0; rcnt = 0; wcnt = 0;
            end else begin
                if (p_req_v && mem_req_ready) begin
                    rcnt = 0; beat_no = 0;
                end
                if (p_rsp_r && mem_rsp_valid && mem_q.size() > 0) begin
                    void'(mem_q.pop_front());
                    beat_no++;
                    wcnt = 0;
                end
            end
            mem_req_ready = mem_req_valid && (rcnt >= req_wait);
            if (mem_req_valid && !mem_req_ready) rcnt++;
            if (mem_q.size() > 0 && (hold || (mem_rsp_ready && wcnt >= beat_wait))) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_q[0];
                mem_rsp_last  = (beat_no == 7) != (beat_no == bad_beat);
            end else begin
                mem_rsp_valid = 1'b0;
                mem_rsp_last  = 1'b0;
                if (mem_rsp_ready) wcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (ram_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL ram_write: unexpected write idx %h off %h data %h (cycle %0d)",
                         ram_index, ram_offset, ram_data, cyc);
            end else begin
                check("ram_write", 64'({err, ram_index, ram_offset, ram_data}), 64'(exp_q.pop_front()));
            end
        end
        if (done === 1'b1) begin
            done_cyc_q.push_back(cyc);
            done_err_q.push_back(err);
        end
        if (mem_rsp_ready === 1'b1) rdy_q.push_back(cyc);
    end

    task automatic start_fill(input logic [31:0] addr, output int c0);
        int n;
        for (int b = 0; b < 8; b++) begin
            for (int k = 0; k < 8; k++) begin
                exp_q.push_back({(bad_beat >= 0 && b >= bad_beat), addr[11:6], 6'(b * 8 + k),
                                 8'(fill_data[b] >> (8 * k))});
            end
            mem_q.push_back(fill_data[b]);
        end
        refill_valid = 1'b1;
        refill_addr  = addr;
        n = 0;
        while (!refill_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        c0 = cyc;
        if (!refill_ready) begin
            timeout_fail("refill_accept");
            refill_valid = 1'b0;
            return;
        end
        check("addr_hold", 64'(mem_req_addr), 64'(prev_line));
        check("index_hold", 64'(ram_index), 64'(prev_index));
        @(posedge clk); #1;
        refill_valid = 1'b0;
        check("req_valid", 64'(mem_req_valid), 64'(1));
        check("req_addr", 64'(mem_req_addr), 64'(addr & ~32'h3f));
        check("err_clear", 64'(err), 64'(0));
        prev_line  = addr & ~32'h3f;
        prev_index = addr[11:6];
    endtask

    task automatic wait_done(input int c0, input int extra, input logic exp_err, input bit final_fill);
        int   n;
        int   dc;
        logic de;
        n = 0;
        while (done_cyc_q.size() == 0 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (done_cyc_q.size() == 0) begin
            timeout_fail("done_wait");
            return;
        end
        dc = done_cyc_q.pop_front();
        de = done_err_q.pop_front();
        check("done_cycle", 64'(dc - c0), 64'(74 + extra));
        check("done_err", 64'(de), 64'(exp_err));
        if (final_fill) begin
            check("writes_left", 64'(exp_q.size()), 64'(0));
            check("ready_after", 64'(refill_ready), 64'(1));
        end
    endtask

    task automatic random_data();
        for (int b = 0; b < 8; b++) fill_data[b] = {$urandom, $urandom};
    endtask

    initial begin : main
        int c0, c1, n;
        rst = 1'b1; refill_valid = 1'b0; refill_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(refill_ready), 64'(1));
        check("rst_outs", 64'({mem_req_valid, mem_rsp_ready, ram_wen, done, err}), 64'(0));
        check("rst_ram", 64'({ram_index, ram_offset, ram_data}), 64'(0));
        check("rst_addr", 64'(mem_req_addr), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic fill
        for (int b = 0; b < 8; b++)
            fill_data[b] = 64'h0807060504030201 + 64'(b) * 64'h0808080808080808;
        start_fill(32'h0000_1A40, c0);
        wait_done(c0, 0, 1'b0, 1'b1);

        // Back-pressure with valid held continuously
        hold = 1; rdy_q.delete(); random_data();
        start_fill($urandom, c0);
        wait_done(c0, 0, 1'b0, 1'b1);
        check("rdy_count", 64'(rdy_q.size()), 64'(8));
        for (int i = 1; i < rdy_q.size(); i++)
            check("rdy_spacing", 64'(rdy_q[i] - rdy_q[i-1]), 64'(9));
        hold = 0;

        // Wait states
        req_wait = 3; beat_wait = 2; random_data();
        start_fill($urandom, c0);
        wait_done(c0, 19, 1'b0, 1'b1);
        req_wait = 0; beat_wait = 0;

        // Early last on beat 5, then a clean fill clears err
        bad_beat = 5; random_data();
        start_fill($urandom, c0);
        wait_done(c0, 0, 1'b1, 1'b1);
        bad_beat = -1; random_data();
        start_fill($urandom, c0);
        wait_done(c0, 0, 1'b0, 1'b1);

        // Reset during beat 3 writes
        random_data();
        start_fill($urandom, c0);
        n = 0;
        while (!(ram_wen && ram_offset[5:3] == 3'd3) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) timeout_fail("beat3_wait");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        check("abort_wen", 64'(ram_wen), 64'(0));
        check("abort_ready", 64'(refill_ready), 64'(1));
        check("abort_hs", 64'({mem_req_valid, mem_rsp_ready, done}), 64'(0));
        prev_line = '0; prev_index = '0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_no_done", 64'(done_cyc_q.size()), 64'(0));
        done_cyc_q.delete(); done_err_q.delete();
        random_data();
        start_fill($urandom, c0);
        wait_done(c0, 0, 1'b0, 1'b1);

        // Second request arrives during BEAT and waits for IDLE
        random_data();
        start_fill(32'h0000_2FC0, c0);
        n = 0;
        while (!mem_rsp_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!mem_rsp_ready) timeout_fail("beat_wait");
        random_data();
        start_fill(32'h0000_0A80, c1);
        check("busy_accept", 64'(c1 - c0), 64'(75));
        wait_done(c0, 0, 1'b0, 1'b0);
        wait_done(c1, 0, 1'b0, 1'b1);

        // Randomised fills
        for (int t = 0; t < 4; t++) begin
            req_wait  = int'($urandom_range(0, 3));
            beat_wait = int'($urandom_range(0, 2));
            bad_beat  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
            random_data();
            start_fill($urandom, c0);
            wait_done(c0, req_wait + 8 * beat_wait, bad_beat >= 0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
